// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pushbutton pins and the conditioned game-side signals.
interface button_conditioner_if;
  logic btn_start_raw;
  logic btn_play_raw;
  logic start;
  logic play;
  logic start_level;
  logic play_level;

  // Board/stimulus side: drives raw buttons, consumes conditioned outputs.
  modport master (
    output btn_start_raw,
    output btn_play_raw,
    input  start,
    input  play,
    input  start_level,
    input  play_level
  );

  // Conditioner side.
  modport slave (
    input  btn_start_raw,
    input  btn_play_raw,
    output start,
    output play,
    output start_level,
    output play_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: 2-flop synchronizer, counting debouncer
// and registered rising-edge press pulse per channel. Channel 0 is start,
// channel 1 is play; start wins when both pulses land on the same edge.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input logic           clk,
  input logic           reset,
  button_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       raw;
  logic [1:0]       s1_q, s2_q;
  logic [1:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       rise;
  logic             start_q, start_d;
  logic             play_q, play_d;

  assign raw = {bus.btn_play_raw, bus.btn_start_raw};

  // Debounce next-state: count while the synchronized input disagrees with
  // the level, flip at the threshold, any agreement restarts from zero.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      db_d[ch]  = db_q[ch];
      cnt_d[ch] = '0;
      if (s2_q[ch] != db_q[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          db_d[ch] = s2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        end
      end
    end
    rise    = db_d & ~db_q;
    start_d = rise[0];
    play_d  = rise[1] & ~rise[0];
  end

  // State registers: synchronizer, debounced levels, counters and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      start_q  <= 1'b0;
      play_q   <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      db_q     <= db_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      start_q  <= start_d;
      play_q   <= play_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.play        = play_q;
  assign bus.start_level = db_q[0];
  assign bus.play_level  = db_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and a 40 ns clock.
// Edge k of a case is the k-th rising edge after reset is released; a raw
// input set before edge k is first sampled at edge k, so a press sampled at
// edge E0 shows up on the outputs at edge E0+5.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #20 clk = ~clk;

  typedef struct {
    string name;
    int    s_on;   int s_len;   // start raw high for edges [s_on, s_on+s_len)
    int    p_on;   int p_len;
    int    exp_s;  int exp_p;   // edge of the single expected pulse, -1 = none
    int    sl_r;   int sl_f;    // start_level high for edges [sl_r, sl_f)
    int    pl_r;   int pl_f;
    int    ncyc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int k, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s edge %0d: got %b expected %b", nm, k, got, exp);
    end
  endtask

  task automatic check_all(input string nm, input int k,
                           input logic es, input logic ep, input logic esl, input logic epl);
    chk({nm, ".start"},       k, bus.start,       es);
    chk({nm, ".play"},        k, bus.play,        ep);
    chk({nm, ".start_level"}, k, bus.start_level, esl);
    chk({nm, ".play_level"},  k, bus.play_level,  epl);
  endtask

  task automatic step(input logic r, input logic sr, input logic pr);
    @(negedge clk);
    reset             = r;
    bus.btn_start_raw = sr;
    bus.btn_play_raw  = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all({nm, ".reset"}, -1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic in_win(input int k, input int r, input int f);
    return (r >= 0) && (k >= r) && (k < f);
  endfunction

  initial begin
    reset = 1'b1;
    bus.btn_start_raw = 1'b0;
    bus.btn_play_raw  = 1'b0;

    //          name           s_on s_len p_on p_len exp_s exp_p sl_r sl_f pl_r pl_f ncyc
    vecs[0] = '{"clean_start",  2,  20,   -1,  0,    7,   -1,    7,  27,  -1,  -1,  40};
    vecs[1] = '{"play_hold",   -1,   0,    2, 30,   -1,    7,   -1,  -1,   7,  37,  45};
    vecs[2] = '{"simul",        2,  10,    2, 10,    7,   -1,    7,  17,   7,  17,  25};
    vecs[3] = '{"short3",       3,   3,   -1,  0,   -1,   -1,   -1,  -1,  -1,  -1,  20};
    vecs[4] = '{"exact4",      -1,   0,    3,  4,   -1,    8,   -1,  -1,   8,  12,  20};
    vecs[5] = '{"staggered",    2,  10,    3, 10,    7,    8,    7,  17,   8,  18,  25};

    foreach (vecs[i]) begin
      do_reset(vecs[i].name);
      for (int k = 0; k < vecs[i].ncyc; k++) begin
        step(1'b0, in_win(k, vecs[i].s_on, vecs[i].s_on + vecs[i].s_len),
                   in_win(k, vecs[i].p_on, vecs[i].p_on + vecs[i].p_len));
        check_all(vecs[i].name, k,
                  k == vecs[i].exp_s, k == vecs[i].exp_p,
                  in_win(k, vecs[i].sl_r, vecs[i].sl_f),
                  in_win(k, vecs[i].pl_r, vecs[i].pl_f));
      end
    end

    // Bounce: play high {2,3}, low {4,5}, high {6,7}, low {8,9}, then high from 10.
    do_reset("bounce");
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 1'b0, (k == 2 || k == 3 || k == 6 || k == 7 || k >= 10));
      check_all("bounce", k, 1'b0, k == 15, 1'b0, k >= 15);
    end

    // Reset mid-debounce: start held from edge 2, reset sampled high at edge 4.
    do_reset("midrst");
    for (int k = 0; k < 21; k++) begin
      step(k == 4, k >= 2, 1'b0);
      check_all("midrst", k, k == 10, 1'b0, k >= 10, 1'b0);
    end

    // Repeated presses: 8 high / 8 low starting at edge 2, three times.
    begin
      int npulse;
      npulse = 0;
      do_reset("repeat");
      for (int k = 0; k < 50; k++) begin
        step(1'b0, (k >= 2) && (k < 50 - 2) && (((k - 2) % 16) < 8), 1'b0);
        if (bus.start === 1'b1) npulse++;
        check_all("repeat", k, (k == 7 || k == 23 || k == 39), 1'b0,
                  (k >= 7) && (k < 47) && (((k - 7) % 16) < 8), 1'b0);
      end
      tests++;
      if (npulse != 3) begin
        fails++;
        $display("FAIL repeat.count: got %0d pulses expected 3", npulse);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
